// File: rtl/serial_seq_detector_pkg.sv
// Shared constants for the serial 1101 detector.
// Holds the FSM state encodings and the reference pattern. Each state is named
// after the longest prefix of the pattern that has been seen.
package serial_seq_detector_pkg;

  localparam logic [2:0] S0    = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S11   = 3'd2;
  localparam logic [2:0] S110  = 3'd3;
  localparam logic [2:0] S1101 = 3'd4;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/serial_seq_detector_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
// Ports:
//   Clk   - rising-edge clock
//   Rst_n - synchronous active-low reset
//   inc   - count one event on this edge
//   clr   - synchronous clear of cnt/ovf; wins over inc
//   cnt   - current count, holds at 2^CNT_W-1
//   ovf   - set by an inc while saturated; cleared only by Rst_n or clr
module serial_seq_detector_sat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/serial_seq_detector.sv
// Overlapping 1101 serial pattern detector (Moore FSM) with match counter.
// Ports:
//   Clk      - rising-edge clock
//   Rst_n    - synchronous active-low reset, priority over everything
//   Din      - serial data bit from the upstream flip-flop
//   En       - sample enable; Din is consumed only when En=1
//   Clr      - synchronous clear of Count/Overflow; FSM unaffected
//   Match    - registered one-cycle pulse per detected pattern
//   Count    - saturating match count
//   Overflow - sticky flag, match seen while Count saturated
//   State    - current FSM state code, for debug
module serial_seq_detector
  import serial_seq_detector_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Din,
  input  logic             En,
  input  logic             Clr,
  output logic             Match,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic [2:0]       State
);

  logic [2:0] state_q, state_d;
  logic       match_q, match_d;

  always_comb begin
    state_d = state_q;
    if (state_q > S1101) begin
      // Illegal codes recover regardless of En.
      state_d = S0;
    end else if (En) begin
      case (state_q)
        S0:      state_d = Din ? S1  : S0;
        S1:      state_d = Din ? S11 : S0;
        S11:     state_d = Din ? S11 : S110;
        S110:    state_d = Din ? S1101 : S0;
        S1101:   state_d = Din ? S11 : S0;  // overlap: trailing 1 starts "11"
        default: state_d = S0;
      endcase
    end
  end

  // Gating with En means a held S1101 does not re-pulse.
  assign match_d = En && (state_d == S1101);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  serial_seq_detector_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (match_d),
    .clr   (Clr),
    .cnt   (Count),
    .ovf   (Overflow)
  );

  assign Match = match_q;
  assign State = state_q;

endmodule

// File: tb/tb_serial_seq_detector.sv
module tb_serial_seq_detector;
  import serial_seq_detector_pkg::*;

  localparam int unsigned CntW = 2;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic            Clk;
  logic            Rst_n;
  logic            Din;
  logic            En;
  logic            Clr;
  logic            Match;
  logic [CntW-1:0] Count;
  logic            Overflow;
  logic [2:0]      State;

  serial_seq_detector #(
    .CNT_W (CntW)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Din      (Din),
    .En       (En),
    .Clr      (Clr),
    .Match    (Match),
    .Count    (Count),
    .Overflow (Overflow),
    .State    (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic            match;
    logic [CntW-1:0] count;
    logic            ovf;
    logic [2:0]      state;
  } exp_t;

  exp_t q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: history of accepted bits, independent of FSM encoding.
  logic [3:0]  m_hist;
  int          m_len;
  int unsigned m_count;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_state(input logic [3:0] h, input int len);
    logic [2:0] h3;
    logic [1:0] h2;
    h3 = h[2:0];
    h2 = h[1:0];
    if (len >= 4 && h == PATTERN) return 3'd4;
    if (len >= 3 && h3 == 3'b110) return 3'd3;
    if (len >= 2 && h2 == 2'b11) return 3'd2;
    if (len >= 1 && h[0]) return 3'd1;
    return 3'd0;
  endfunction

  // One clock edge: predict, push, drive, wait, pop, compare.
  task automatic step(input logic rstn, input logic en, input logic clr, input logic din,
                      input string tag);
    exp_t e;
    exp_t got;
    logic m;
    m = 1'b0;
    if (!rstn) begin
      m_hist  = 4'b0;
      m_len   = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      if (en) begin
        m_hist = {m_hist[2:0], din};
        if (m_len < 8) m_len++;
        m = (m_len >= 4) && (m_hist == PATTERN);
      end
      if (clr) begin
        m_count = 0;
        m_ovf   = 1'b0;
      end else if (m) begin
        if (m_count == CntMax) m_ovf = 1'b1;
        else m_count++;
      end
    end
    e.match = m;
    e.count = m_count[CntW-1:0];
    e.ovf   = m_ovf;
    e.state = model_state(m_hist, m_len);
    q.push_back(e);

    Rst_n = rstn;
    En    = en;
    Clr   = clr;
    Din   = din;
    @(posedge Clk);
    #1;
    got = q.pop_front();
    chk({tag, ".match"}, {7'b0, Match}, {7'b0, got.match});
    chk({tag, ".count"}, {{(8 - CntW){1'b0}}, Count}, {{(8 - CntW){1'b0}}, got.count});
    chk({tag, ".ovf"}, {7'b0, Overflow}, {7'b0, got.ovf});
    chk({tag, ".state"}, {5'b0, State}, {5'b0, got.state});
  endtask

  task automatic bits(input logic [15:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, 1'b0, v[i], tag);
  endtask

  initial begin
    Rst_n = 1'b0;
    En    = 1'b0;
    Clr   = 1'b0;
    Din   = 1'b0;
    m_hist  = 4'b0;
    m_len   = 0;
    m_count = 0;
    m_ovf   = 1'b0;
    #1;

    // Reset, then idle zeros.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst");
    step(1'b0, 1'b1, 1'b1, 1'b1, "rst");
    chk("rst_state", {5'b0, State}, 8'd0);
    bits(16'b000, 3, "zeros");

    // Single pattern; the trailing 0 shows Match lasting one cycle.
    bits(16'b11010, 5, "single");
    chk("single_count", {6'b0, Count}, 8'd1);

    // Overlap.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst2");
    bits(16'b1101101, 7, "overlap");
    chk("overlap_state", {5'b0, State}, 8'd4);
    chk("overlap_count", {6'b0, Count}, 8'd2);
    bits(16'b0, 1, "overlap_tail");

    // En gating mid-pattern.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst3");
    bits(16'b110, 3, "gate");
    step(1'b1, 1'b0, 1'b0, 1'b1, "gap");
    step(1'b1, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b0, 1'b0, 1'b1, "gap");
    chk("gap_state", {5'b0, State}, 8'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, "gate_done");
    // En drops while in S1101: Match must fall and not repeat.
    step(1'b1, 1'b0, 1'b0, 1'b1, "gate_hold");
    step(1'b1, 1'b0, 1'b0, 1'b1, "gate_hold");

    // Saturation with a 2-bit counter.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst4");
    for (int k = 0; k < 4; k++) bits(16'b11010, 5, "sat");
    chk("sat_ovf", {7'b0, Overflow}, 8'd1);
    chk("sat_count", {6'b0, Count}, 8'd3);
    bits(16'b11, 2, "pre_clr");
    step(1'b1, 1'b0, 1'b1, 1'b0, "clr");
    chk("clr_state", {5'b0, State}, 8'd2);

    // Reset on the completing edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst5");
    bits(16'b11010, 5, "pre_coll");
    bits(16'b110, 3, "coll_rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, "coll_rst_edge");
    // Partial prefix is not credited after reset.
    bits(16'b1, 1, "after_rst");
    chk("after_rst_state", {5'b0, State}, 8'd1);

    // Clr on the completing edge: Match pulses, Count cleared.
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst6");
    bits(16'b11010, 5, "pre_clrcoll");
    bits(16'b110, 3, "clrcoll");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clrcoll_edge");
    chk("clrcoll_match", {7'b0, Match}, 8'd1);
    chk("clrcoll_count", {6'b0, Count}, 8'd0);

    // Random stream with random enable and occasional clear.
    for (int k = 0; k < 200; k++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
           $urandom_range(0, 1) != 0, "rand");
    end

    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
